// File: rtl/rot_register_bank_pkg.sv
// Shared widths and head-pointer operation codes for the multi-lane circular register bank.
package rot_register_bank_pkg;

  function automatic int pw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // A single lane still needs a one-bit select so the ports keep a legal width.
  function automatic int cw_of(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef enum logic [1:0] {
    HEAD_HOLD,
    HEAD_STEP,
    HEAD_ZERO
  } head_op_e;

endpackage

// File: rtl/rot_register_bank_if.sv
// Control, write, readback and stream signals of the register bank, grouped as one bus.
interface rot_register_bank_if
  import rot_register_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
) ();
  localparam int PW = pw_of(DEPTH);
  localparam int CW = cw_of(CHANNELS);

  logic                      advance;
  logic                      realign;
  logic                      clear;
  logic                      wr_en;
  logic [CW-1:0]             wr_chan;
  logic [PW-1:0]             wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [CW-1:0]             rd_chan;
  logic [PW-1:0]             rd_addr;
  logic [WIDTH-1:0]          rd_data;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [PW-1:0]             head_idx;
  logic                      wrap;

  modport master (
    output advance, realign, clear, wr_en, wr_chan, wr_addr, wr_data, rd_chan, rd_addr,
    input  rd_data, data_out, head_idx, wrap
  );

  modport slave (
    input  advance, realign, clear, wr_en, wr_chan, wr_addr, wr_data, rd_chan, rd_addr,
    output rd_data, data_out, head_idx, wrap
  );

endinterface

// File: rtl/rot_register_bank_lane.sv
// One lane of slot storage: write decode, clear, head-slot mux and readback mux.
module rot_register_bank_lane
  import rot_register_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [pw_of(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [pw_of(DEPTH)-1:0] head_idx,
  input  logic [pw_of(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]       head_data,
  output logic [WIDTH-1:0]       rd_data
);

  logic [WIDTH-1:0] slot [DEPTH];

  // Decoding by comparison drops writes to addresses past DEPTH-1 when DEPTH is not a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(wr_addr) == i) slot[i] <= wr_data;
      end
    end
  end

  always_comb begin
    head_data = '0;
    rd_data   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(head_idx) == i) head_data = slot[i];
      if (int'(rd_addr) == i)  rd_data   = slot[i];
    end
  end

endmodule

// File: rtl/rot_register_bank.sv
// Multi-lane circular register bank: shared head pointer and wrap pulse over per-lane slot storage.
module rot_register_bank
  import rot_register_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
) (
  input logic                clk,
  input logic                rst_n,
  rot_register_bank_if.slave bus
);
  localparam int PW = pw_of(DEPTH);

  head_op_e                  head_op;
  logic [PW-1:0]             head_idx_q;
  logic [PW-1:0]             head_next;
  logic                      wrap_q;
  logic                      at_last;
  logic [WIDTH-1:0]          lane_head [CHANNELS];
  logic [WIDTH-1:0]          lane_rd   [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] data_out_w;
  logic [WIDTH-1:0]          rd_data_w;

  assign at_last = (int'(head_idx_q) == DEPTH - 1);

  // Clear and realign both zero the head and outrank advance.
  always_comb begin
    head_op = HEAD_HOLD;
    if (bus.clear || bus.realign) head_op = HEAD_ZERO;
    else if (bus.advance)         head_op = HEAD_STEP;
  end

  always_comb begin
    head_next = head_idx_q;
    case (head_op)
      HEAD_ZERO: head_next = '0;
      HEAD_STEP: head_next = at_last ? '0 : head_idx_q + PW'(1);
      default:   head_next = head_idx_q;
    endcase
  end

  // Head pointer and wrap register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_idx_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      head_idx_q <= head_next;
      wrap_q     <= (head_op == HEAD_STEP) && at_last;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic lane_wr;
    assign lane_wr = bus.wr_en && !bus.clear && (int'(bus.wr_chan) == c);

    rot_register_bank_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (bus.clear),
      .wr_en     (lane_wr),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .head_idx  (head_idx_q),
      .rd_addr   (bus.rd_addr),
      .head_data (lane_head[c]),
      .rd_data   (lane_rd[c])
    );

    assign data_out_w[c*WIDTH +: WIDTH] = lane_head[c];
  end

  // An out-of-range lane select falls through to zero.
  always_comb begin
    rd_data_w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(bus.rd_chan) == c) rd_data_w = lane_rd[c];
    end
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.data_out = data_out_w;
  assign bus.head_idx = head_idx_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_rot_register_bank.sv
// Directed bench for rot_register_bank: an 8-deep 2-lane build and a 5-deep 3-lane build.
module tb_rot_register_bank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  rot_register_bank_if #(.WIDTH(4), .DEPTH(8), .CHANNELS(2)) bus8 ();
  rot_register_bank_if #(.WIDTH(4), .DEPTH(5), .CHANNELS(3)) bus5 ();

  rot_register_bank #(.WIDTH(4), .DEPTH(8), .CHANNELS(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  rot_register_bank #(.WIDTH(4), .DEPTH(5), .CHANNELS(3)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus8.advance = 1'b0; bus8.realign = 1'b0; bus8.clear = 1'b0; bus8.wr_en = 1'b0;
    bus8.wr_chan = '0;   bus8.wr_addr = '0;   bus8.wr_data = '0;  bus8.rd_chan = '0;
    bus8.rd_addr = '0;
    bus5.advance = 1'b0; bus5.realign = 1'b0; bus5.clear = 1'b0; bus5.wr_en = 1'b0;
    bus5.wr_chan = '0;   bus5.wr_addr = '0;   bus5.wr_data = '0;  bus5.rd_chan = '0;
    bus5.rd_addr = '0;
  endtask

  task automatic wr8(input int ch, input int a, input int d);
    bus8.wr_en = 1'b1; bus8.wr_chan = 1'(ch); bus8.wr_addr = 3'(a); bus8.wr_data = 4'(d);
    step();
    bus8.wr_en = 1'b0;
  endtask

  task automatic wr5(input int ch, input int a, input int d);
    bus5.wr_en = 1'b1; bus5.wr_chan = 2'(ch); bus5.wr_addr = 3'(a); bus5.wr_data = 4'(d);
    step();
    bus5.wr_en = 1'b0;
  endtask

  task automatic rd8(input string tag, input int ch, input int a, input int exp);
    bus8.rd_chan = 1'(ch); bus8.rd_addr = 3'(a);
    #1;
    check(tag, 32'(bus8.rd_data), 32'(exp));
  endtask

  task automatic rd5(input string tag, input int ch, input int a, input int exp);
    bus5.rd_chan = 2'(ch); bus5.rd_addr = 3'(a);
    #1;
    check(tag, 32'(bus5.rd_data), 32'(exp));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus8.advance = 1'($urandom); bus8.realign = 1'($urandom); bus8.clear = 1'($urandom);
      bus8.wr_en   = 1'($urandom); bus8.wr_chan = 1'($urandom); bus8.wr_addr = 3'($urandom);
      bus8.wr_data = 4'($urandom); bus8.rd_chan = 1'($urandom); bus8.rd_addr = 3'($urandom);
      bus5.advance = 1'($urandom); bus5.wr_en   = 1'($urandom); bus5.wr_chan = 2'($urandom);
      bus5.wr_addr = 3'($urandom); bus5.wr_data = 4'($urandom);
      step();
    end
    check("rst_data_out", 32'(bus8.data_out), 32'h0);
    check("rst_head",     32'(bus8.head_idx), 32'h0);
    check("rst_wrap",     32'(bus8.wrap),     32'h0);
    check("rst_head5",    32'(bus5.head_idx), 32'h0);
    check("rst_data5",    32'(bus5.data_out), 32'h0);
    idle();
    rst_n = 1'b1;
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < 8; a++) rd8("rst_rd", ch, a, 0);

    // Fill lane 0 with k+1 and stream it through one full revolution.
    for (int k = 0; k < 8; k++) wr8(0, k, k + 1);
    rd8("fill_rd3", 0, 3, 4);
    check("fill_head0", 32'(bus8.data_out), 32'h01);
    bus8.advance = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("adv_data", 32'(bus8.data_out), 32'((i % 8) + 1));
      check("adv_head", 32'(bus8.head_idx), 32'(i % 8));
      check("adv_wrap", 32'(bus8.wrap),     32'(i == 8));
    end
    bus8.advance = 1'b0;
    step();
    check("wrap_drop", 32'(bus8.wrap), 32'h0);
    check("hold_head", 32'(bus8.head_idx), 32'h0);

    // Write to the head slot while advancing: head moves on, value returns a lap later.
    bus8.advance = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus8.advance = 1'b0;
    check("sim_head3", 32'(bus8.head_idx), 32'h3);
    bus8.wr_en = 1'b1; bus8.wr_chan = 1'b0; bus8.wr_addr = 3'd3; bus8.wr_data = 4'hF;
    bus8.advance = 1'b1;
    rd8("sim_rd_pre", 0, 3, 4);
    step();
    bus8.wr_en = 1'b0;
    check("sim_adv_data", 32'(bus8.data_out), 32'h05);
    check("sim_adv_head", 32'(bus8.head_idx), 32'h4);
    rd8("sim_rd_post", 0, 3, 'hF);
    for (int i = 0; i < 7; i++) step();
    bus8.advance = 1'b0;
    check("sim_lap_head", 32'(bus8.head_idx), 32'h3);
    check("sim_lap_data", 32'(bus8.data_out), 32'h0F);
    bus8.wr_en = 1'b1; bus8.wr_chan = 1'b0; bus8.wr_addr = 3'd3; bus8.wr_data = 4'h6;
    rd8("nobypass_rd", 0, 3, 'hF);
    step();
    bus8.wr_en = 1'b0;
    check("hold_wr_data", 32'(bus8.data_out), 32'h06);
    check("hold_wr_head", 32'(bus8.head_idx), 32'h3);

    // Independent lanes, reached via realign then two advances.
    wr8(1, 2, 'hA);
    wr8(0, 2, 5);
    bus8.realign = 1'b1; bus8.advance = 1'b1;
    step();
    bus8.realign = 1'b0;
    check("realign_head", 32'(bus8.head_idx), 32'h0);
    check("realign_wrap", 32'(bus8.wrap),     32'h0);
    for (int i = 0; i < 2; i++) step();
    bus8.advance = 1'b0;
    check("lanes_head", 32'(bus8.head_idx), 32'h2);
    check("lanes_data", 32'(bus8.data_out), 32'hA5);

    // Clear beats realign, advance and write at the wrap point.
    bus8.advance = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus8.advance = 1'b0;
    check("prio_head7", 32'(bus8.head_idx), 32'h7);
    check("prio_data7", 32'(bus8.data_out), 32'h08);
    bus8.clear = 1'b1; bus8.realign = 1'b1; bus8.advance = 1'b1;
    bus8.wr_en = 1'b1; bus8.wr_chan = 1'b0; bus8.wr_addr = 3'd0; bus8.wr_data = 4'h9;
    step();
    bus8.clear = 1'b0; bus8.realign = 1'b0; bus8.advance = 1'b0; bus8.wr_en = 1'b0;
    check("clr_head", 32'(bus8.head_idx), 32'h0);
    check("clr_wrap", 32'(bus8.wrap),     32'h0);
    check("clr_data", 32'(bus8.data_out), 32'h0);
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < 8; a++) rd8("clr_rd", ch, a, 0);
    bus8.advance = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("ra_head7", 32'(bus8.head_idx), 32'h7);
    bus8.realign = 1'b1;
    step();
    bus8.realign = 1'b0; bus8.advance = 1'b0;
    check("ra_head", 32'(bus8.head_idx), 32'h0);
    check("ra_wrap", 32'(bus8.wrap),     32'h0);

    // Reset in the middle of activity.
    wr8(1, 0, 'hC);
    check("pre_rst_data", 32'(bus8.data_out), 32'hC0);
    bus8.advance = 1'b1;
    bus8.wr_en = 1'b1; bus8.wr_chan = 1'b0; bus8.wr_addr = 3'd1; bus8.wr_data = 4'h3;
    rst_n = 1'b0;
    step();
    idle();
    rst_n = 1'b1;
    check("mid_rst_head", 32'(bus8.head_idx), 32'h0);
    check("mid_rst_data", 32'(bus8.data_out), 32'h0);
    check("mid_rst_wrap", 32'(bus8.wrap),     32'h0);
    rd8("mid_rst_rd1", 1, 0, 0);
    rd8("mid_rst_rd0", 0, 1, 0);

    // Non-power-of-two depth and an odd lane count.
    for (int k = 0; k < 5; k++) wr5(0, k, k + 1);
    check("d5_data0", 32'(bus5.data_out), 32'h001);
    bus5.advance = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("d5_head", 32'(bus5.head_idx), 32'(i % 5));
      check("d5_wrap", 32'(bus5.wrap),     32'(i % 5 == 0));
    end
    bus5.advance = 1'b0;
    wr5(0, 5, 'hF);
    wr5(0, 6, 'hF);
    wr5(0, 7, 'hF);
    wr5(3, 0, 'hF);
    for (int k = 0; k < 5; k++) rd5("d5_rd", 0, k, k + 1);
    rd5("d5_rd_l1", 1, 0, 0);
    rd5("d5_rd_l2", 2, 0, 0);
    rd5("d5_rd_oob", 0, 6, 0);
    rd5("d5_rd_badch", 3, 0, 0);
    check("d5_data_end", 32'(bus5.data_out), 32'h001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
